// File: rtl/mem_burst_rd_master.sv
// mem_burst_rd_master
//   Burst read engine for the 16-byte memory request/response interface.
//   A command (base address, line count) is turned into consecutive 16B
//   read requests. At most MAX_OUTSTANDING requests are in flight at once.
//   Responses pass straight through to the client port, in order.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   cmd_val/cmd_rdy             burst command handshake (cmd_addr, cmd_lines)
//   req_msg/req_val/req_rdy     request stream to memory
//   resp_msg/resp_val/resp_rdy  response stream from memory
//   out_data/out_last           line data to the client, last-line flag
//   out_val/out_rdy             client handshake
//   busy                        high while a burst is running
//   done                        one-cycle pulse when a burst completes
//   err                         one-cycle pulse after a response whose opaque
//                               tag does not match the expected sequence

package mem_16B_pkg;
  localparam logic [2:0] MEM_READ  = 3'd0;
  localparam logic [2:0] MEM_WRITE = 3'd1;

  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;
endpackage

module mem_burst_rd_master
  import mem_16B_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_val,
  output logic                 cmd_rdy,
  input  logic [31:0]          cmd_addr,
  input  logic [CNT_W-1:0]     cmd_lines,
  output mem_req_16B_t         req_msg,
  output logic                 req_val,
  input  logic                 req_rdy,
  input  mem_resp_16B_t        resp_msg,
  input  logic                 resp_val,
  output logic                 resp_rdy,
  output logic [127:0]         out_data,
  output logic                 out_last,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [31:0]        r_base;
  logic [CNT_W-1:0]   r_total;
  logic [CNT_W-1:0]   r_issued;
  logic [CNT_W-1:0]   r_received;
  logic [OW-1:0]      r_outstanding;
  logic               r_done;
  logic               r_err;

  logic               w_cmd_hs;
  logic               w_req_hs;
  logic               w_resp_hs;
  logic               w_last;
  logic [31:0]        w_issued_ext;
  logic               w_unused;

  assign w_cmd_hs     = cmd_val && cmd_rdy;
  assign w_req_hs     = req_val && req_rdy;
  assign w_resp_hs    = resp_val && resp_rdy;
  assign w_last       = (r_received == r_total - CNT_W'(1));
  assign w_issued_ext = 32'(r_issued);

  // Fields that this initiator never looks at.
  assign w_unused = ^{cmd_addr[3:0], resp_msg.type_, resp_msg.test, resp_msg.len};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a zero-line command never leaves IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_cmd_hs && (cmd_lines != '0)) w_state_next = S_RUN;
      S_RUN:  if (w_resp_hs && w_last)           w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs; req_val is derived from registered state only so req_msg is
  // stable for as long as the memory holds off req_rdy.
  always_comb begin
    cmd_rdy  = (r_state == S_IDLE);
    busy     = (r_state == S_RUN);
    req_val  = (r_state == S_RUN) && (r_issued < r_total) &&
               (r_outstanding < OW'(MAX_OUTSTANDING));
    out_val  = resp_val && (r_state == S_RUN);
    resp_rdy = out_rdy && (r_state == S_RUN);
    out_data = resp_msg.data;
    out_last = w_last;
    done     = r_done;
    err      = r_err;

    req_msg        = '0;
    req_msg.type_  = MEM_READ;
    req_msg.opaque = r_issued[7:0];
    req_msg.addr   = r_base + {w_issued_ext[27:0], 4'h0};
  end

  // Burst bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base        <= '0;
      r_total       <= '0;
      r_issued      <= '0;
      r_received    <= '0;
      r_outstanding <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_done <= (w_cmd_hs && (cmd_lines == '0)) || (w_resp_hs && w_last);
      r_err  <= w_resp_hs && (resp_msg.opaque != r_received[7:0]);

      if (w_cmd_hs) begin
        r_base        <= {cmd_addr[31:4], 4'h0};
        r_total       <= cmd_lines;
        r_issued      <= '0;
        r_received    <= '0;
        r_outstanding <= '0;
      end else begin
        if (w_req_hs)  r_issued   <= r_issued + CNT_W'(1);
        if (w_resp_hs) r_received <= r_received + CNT_W'(1);
        // Simultaneous request and response leave the count unchanged.
        case ({w_req_hs, w_resp_hs})
          2'b10:   r_outstanding <= r_outstanding + OW'(1);
          2'b01:   r_outstanding <= r_outstanding - OW'(1);
          default: r_outstanding <= r_outstanding;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_burst_rd_master.sv
// Testbench for mem_burst_rd_master: a queue-based memory responder with
// one-cycle latency, and a reference model that lists the expected request
// addresses/tags and returned lines of each burst directly from its
// base address and line count.

module tb_mem_burst_rd_master;
  import mem_16B_pkg::*;

  localparam int MAXO = 4;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_val;
  logic          cmd_rdy;
  logic [31:0]   cmd_addr;
  logic [CW-1:0] cmd_lines;
  mem_req_16B_t  req_msg;
  logic          req_val;
  logic          req_rdy;
  mem_resp_16B_t resp_msg;
  logic          resp_val;
  logic          resp_rdy;
  logic [127:0]  out_data;
  logic          out_last;
  logic          out_val;
  logic          out_rdy;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  mem_burst_rd_master #(.MAX_OUTSTANDING(MAXO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr), .cmd_lines(cmd_lines),
    .req_msg(req_msg), .req_val(req_val), .req_rdy(req_rdy),
    .resp_msg(resp_msg), .resp_val(resp_val), .resp_rdy(resp_rdy),
    .out_data(out_data), .out_last(out_last), .out_val(out_val), .out_rdy(out_rdy),
    .busy(busy), .done(done), .err(err)
  );

  int checks   = 0;
  int failures = 0;

  // Responder's in-flight requests (address and tag as issued).
  logic [31:0] pq_addr[$];
  logic [7:0]  pq_op[$];

  // Contents of the memory line at a given byte address.
  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {a ^ 32'h5A5A0000, ~a, a + 32'h00001234, {a[15:0], a[31:16]}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One burst. orm: out_rdy 0=always,1=pattern 1,0,0,1,2=random.
  // rrm: req_rdy 0=always,1=random. bad: index of response returned with
  // opaque 5 (-1 none). rst_at: reset once this many lines arrived (0 none).
  task automatic run_burst(input logic [31:0] a, input int n, input int orm,
                           input int rrm, input int bad, input int rst_at);
    logic [31:0] base;
    logic [31:0] exp_addr;
    logic [7:0]  sent_op;
    int          exp_req;
    int          exp_out;
    int          cyc;
    bit          exp_done;
    bit          exp_err;
    bit          req_hs;
    bit          resp_hs;
    base     = {a[31:4], 4'h0};
    exp_req  = 0;
    exp_out  = 0;
    cyc      = 0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    sent_op  = 8'd0;
    pq_addr.delete();
    pq_op.delete();

    @(negedge clk);
    cmd_val   = 1'b1;
    cmd_addr  = a;
    cmd_lines = CW'(n);
    #1 chk("cmd_rdy_idle", cmd_rdy, 1);
    @(negedge clk);
    cmd_val = 1'b0;

    if (n == 0) begin
      #1;
      chk("zero_done", done, 1);
      chk("zero_cmd_rdy", cmd_rdy, 1);
      chk("zero_req_val", req_val, 0);
      chk("zero_busy", busy, 0);
      @(negedge clk);
      #1;
      chk("zero_done_once", done, 0);
      chk("zero_req_val2", req_val, 0);
      $display("burst addr=%08h lines=%0d (empty)", a, n);
      return;
    end

    while (exp_out < n && cyc < 3000) begin
      if (rst_at > 0 && exp_out == rst_at) begin
        rst      = 1'b1;
        resp_val = 1'b0;
        req_rdy  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_cmd_rdy", cmd_rdy, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req_val", req_val, 0);
        chk("rst_out_val", out_val, 0);
        pq_addr.delete();
        pq_op.delete();
        @(negedge clk);
        #1;
        chk("rst_no_done", done, 0);
        chk("rst_cmd_rdy2", cmd_rdy, 1);
        $display("burst addr=%08h lines=%0d reset after %0d lines", a, n, exp_out);
        return;
      end

      req_rdy = (rrm == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      case (orm)
        0:       out_rdy = 1'b1;
        1:       out_rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_rdy = 1'($urandom_range(0, 1));
      endcase
      resp_msg = '0;
      resp_val = (pq_addr.size() > 0);
      if (resp_val) begin
        sent_op         = (exp_out == bad) ? 8'd5 : pq_op[0];
        resp_msg.type_  = MEM_READ;
        resp_msg.opaque = sent_op;
        resp_msg.data   = line_of(pq_addr[0]);
      end
      #1;

      chk("done", done, exp_done);
      chk("err", err, exp_err);
      chk("busy_run", busy, 1);
      chk("cmd_rdy_run", cmd_rdy, 0);
      chk("outstanding_limit", req_val && (pq_addr.size() >= MAXO), 0);
      chk("out_val", out_val, resp_val);
      chk("resp_rdy", resp_rdy, out_rdy);

      req_hs   = req_val && req_rdy;
      resp_hs  = out_val && out_rdy;
      exp_done = 1'b0;
      exp_err  = 1'b0;

      if (req_hs) begin
        exp_addr = base + 32'(exp_req) * 32'd16;
        chk("req_in_range", exp_req < n, 1);
        chk("req_addr", req_msg.addr, exp_addr);
        chk("req_opaque", req_msg.opaque, exp_req[7:0]);
        chk("req_type", req_msg.type_, MEM_READ);
        chk("req_len", req_msg.len, 0);
        pq_addr.push_back(req_msg.addr);
        pq_op.push_back(req_msg.opaque);
        exp_req++;
      end
      if (resp_hs) begin
        exp_addr = base + 32'(exp_out) * 32'd16;
        chk("out_data", out_data, line_of(exp_addr));
        chk("out_last", out_last, exp_out == n - 1);
        exp_err  = (sent_op != exp_out[7:0]);
        exp_done = (exp_out == n - 1);
        void'(pq_addr.pop_front());
        void'(pq_op.pop_front());
        exp_out++;
      end
      cyc++;
      @(negedge clk);
    end

    chk("burst_timeout", cyc < 3000, 1);
    if (orm == 0 && rrm == 0) chk("throughput", cyc, n + 1);

    resp_val = 1'b0;
    resp_msg = '0;
    #1;
    chk("final_done", done, exp_done);
    chk("final_err", err, exp_err);
    chk("final_busy", busy, 0);
    chk("final_cmd_rdy", cmd_rdy, 1);
    chk("final_req_val", req_val, 0);
    @(negedge clk);
    #1;
    chk("done_once", done, 0);
    chk("err_once", err, 0);
    $display("burst addr=%08h lines=%0d reqs=%0d lines_out=%0d cycles=%0d",
             a, n, exp_req, exp_out, cyc);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_val   = 1'b0;
    cmd_addr  = '0;
    cmd_lines = '0;
    req_rdy   = 1'b0;
    resp_val  = 1'b0;
    resp_msg  = '0;
    out_rdy   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_val", req_val, 0);
    chk("reset_out_val", out_val, 0);
    chk("reset_cmd_rdy", cmd_rdy, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    @(negedge clk);
    rst = 1'b0;

    // A response while idle must not be accepted or forwarded.
    @(negedge clk);
    resp_val      = 1'b1;
    out_rdy       = 1'b1;
    resp_msg.data = 128'hABCD;
    #1;
    chk("idle_resp_rdy", resp_rdy, 0);
    chk("idle_out_val", out_val, 0);
    resp_val = 1'b0;

    run_burst(32'h0000_0105, 4, 0, 0, -1, 0);
    run_burst(32'h0000_0105, 4, 1, 0, -1, 0);
    run_burst(32'h0000_0105, 9, 1, 0, -1, 0);
    run_burst(32'h0000_0200, 0, 0, 0, -1, 0);
    run_burst(32'hFFFF_FFE0, 3, 0, 0, -1, 0);
    run_burst(32'h0000_0300, 4, 0, 0, 1, 0);
    run_burst(32'h0000_0400, 6, 0, 0, -1, 2);
    run_burst(32'h0000_0500, 5, 0, 0, -1, 0);
    run_burst(32'h0001_0000, 260, 0, 0, -1, 0);
    for (int i = 0; i < 10; i++) begin
      run_burst($urandom, int'($urandom_range(1, 12)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 1)), -1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
